// File: rtl/bus_checker_pkg.sv
// rtl/bus_checker_pkg.sv - shared types and constants for the bus protocol checker
// Purpose: per-channel FSM state encoding and error-bit indices.
// Ports: none (package).
package bus_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TMO  = 2'd2
  } chk_state_e;

  localparam int ERR_W       = 4;
  localparam int ERR_BOTH    = 0;
  localparam int ERR_DROP    = 1;
  localparam int ERR_MUTATE  = 2;
  localparam int ERR_TIMEOUT = 3;

endpackage

// File: rtl/bus_channel_checker.sv
// rtl/bus_channel_checker.sv - single-channel request/busy protocol monitor
// Purpose: tracks one channel's outstanding request, counts completions and
//          records BOTH/DROP/MUTATE/TIMEOUT violations.
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   clear_i          synchronous clear of flags and counter
//   ren_i, wen_i     read / write request
//   busy_i           slave busy
//   addr_i, wdata_i, byte_en_i  request attributes
//   pending_o        stalled request outstanding
//   err_pulse_o      one-cycle pulse on any newly detected violation
//   err_flags_o      sticky violation bits
//   txn_count_o      saturating completed-transaction count
module bus_channel_checker
  import bus_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                clear_i,
  input  logic                ren_i,
  input  logic                wen_i,
  input  logic                busy_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] byte_en_i,
  output logic                pending_o,
  output logic                err_pulse_o,
  output logic [ERR_W-1:0]    err_flags_o,
  output logic [CNT_W-1:0]    txn_count_o
);

  localparam int BE_W = DATA_W / 8;
  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  chk_state_e        state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              cap_ren_q, cap_ren_d;
  logic              cap_wen_q, cap_wen_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [BE_W-1:0]   cap_be_q, cap_be_d;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;

  logic              pending_q, pending_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_flags_q, err_flags_d;
  logic [CNT_W-1:0]  txn_count_q, txn_count_d;

  logic              req;
  logic              mutate;
  logic              complete;
  logic              capture;
  logic [ERR_W-1:0]  new_err;

  assign req = ren_i | wen_i;

  // Write data only matters for a captured write; reads may leave it floating.
  assign mutate = (cap_ren_q != ren_i) || (cap_wen_q != wen_i) ||
                  (cap_addr_q != addr_i) || (cap_be_q != byte_en_i) ||
                  (cap_wen_q && (cap_wdata_q != wdata_i));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    new_err    = '0;
    complete   = 1'b0;
    capture    = 1'b0;

    if (ren_i && wen_i) begin
      new_err[ERR_BOTH] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          if (!busy_i) begin
            complete = 1'b1;
          end else begin
            capture    = 1'b1;
            wait_cnt_d = WC_W'(1);
            state_d    = WAIT;
          end
        end
      end
      WAIT, TMO: begin
        if (!req) begin
          new_err[ERR_DROP] = 1'b1;
          state_d           = IDLE;
          wait_cnt_d        = '0;
        end else begin
          if (mutate) begin
            new_err[ERR_MUTATE] = 1'b1;
            capture             = 1'b1;
          end
          if (!busy_i) begin
            complete   = 1'b1;
            state_d    = IDLE;
            wait_cnt_d = '0;
          end else if (state_q == WAIT) begin
            // TMO holds the count frozen so the timeout fires only once.
            if (wait_cnt_q == WAIT_LAST) begin
              new_err[ERR_TIMEOUT] = 1'b1;
              state_d              = TMO;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase

    cap_ren_d   = capture ? ren_i     : cap_ren_q;
    cap_wen_d   = capture ? wen_i     : cap_wen_q;
    cap_addr_d  = capture ? addr_i    : cap_addr_q;
    cap_be_d    = capture ? byte_en_i : cap_be_q;
    cap_wdata_d = capture ? wdata_i   : cap_wdata_q;

    // A violation in the clear cycle survives the clear.
    err_flags_d = clear_i ? new_err : (err_flags_q | new_err);
    err_pulse_d = |new_err;
    pending_d   = (state_d != IDLE);

    if (clear_i) begin
      txn_count_d = '0;
    end else if (complete && (txn_count_q != CNT_MAX)) begin
      txn_count_d = txn_count_q + 1'b1;
    end else begin
      txn_count_d = txn_count_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cap_ren_q   <= 1'b0;
      cap_wen_q   <= 1'b0;
      cap_addr_q  <= '0;
      cap_be_q    <= '0;
      cap_wdata_q <= '0;
      pending_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      err_flags_q <= '0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cap_ren_q   <= cap_ren_d;
      cap_wen_q   <= cap_wen_d;
      cap_addr_q  <= cap_addr_d;
      cap_be_q    <= cap_be_d;
      cap_wdata_q <= cap_wdata_d;
      pending_q   <= pending_d;
      err_pulse_q <= err_pulse_d;
      err_flags_q <= err_flags_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign pending_o   = pending_q;
  assign err_pulse_o = err_pulse_q;
  assign err_flags_o = err_flags_q;
  assign txn_count_o = txn_count_q;

endmodule

// File: rtl/bus_protocol_checker.sv
// rtl/bus_protocol_checker.sv - passive multi-channel request/busy bus protocol checker
// Purpose: instantiates one bus_channel_checker per channel, slices the packed
//          buses and reduces all sticky flags into any_err.
// Ports:
//   CLK, nRST       clock, asynchronous active-low reset
//   clear           synchronous clear of flags and counters
//   ren, wen, busy  per-channel request / busy bits
//   addr, wdata, byte_en  packed per-channel attributes, channel 0 in LSBs
//   pending         per-channel stalled-request indicator
//   err_pulse       per-channel new-violation pulse
//   err_flags       packed sticky flags, 4 bits per channel
//   txn_count       packed saturating completion counters
//   any_err         OR of all sticky flags
module bus_protocol_checker
  import bus_checker_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         clear,
  input  logic [NUM_CH-1:0]            ren,
  input  logic [NUM_CH-1:0]            wen,
  input  logic [NUM_CH-1:0]            busy,
  input  logic [NUM_CH*ADDR_W-1:0]     addr,
  input  logic [NUM_CH*DATA_W-1:0]     wdata,
  input  logic [NUM_CH*DATA_W/8-1:0]   byte_en,
  output logic [NUM_CH-1:0]            pending,
  output logic [NUM_CH-1:0]            err_pulse,
  output logic [NUM_CH*ERR_W-1:0]      err_flags,
  output logic [NUM_CH*CNT_W-1:0]      txn_count,
  output logic                         any_err
);

  localparam int BE_W = DATA_W / 8;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bus_channel_checker #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_chk (
      .CLK         (CLK),
      .nRST        (nRST),
      .clear_i     (clear),
      .ren_i       (ren[c]),
      .wen_i       (wen[c]),
      .busy_i      (busy[c]),
      .addr_i      (addr[c*ADDR_W +: ADDR_W]),
      .wdata_i     (wdata[c*DATA_W +: DATA_W]),
      .byte_en_i   (byte_en[c*BE_W +: BE_W]),
      .pending_o   (pending[c]),
      .err_pulse_o (err_pulse[c]),
      .err_flags_o (err_flags[c*ERR_W +: ERR_W]),
      .txn_count_o (txn_count[c*CNT_W +: CNT_W])
    );
  end

  // Derived from registered flags, so it is itself glitch-free.
  assign any_err = |err_flags;

endmodule

// File: tb/tb_bus_protocol_checker.sv
// tb/tb_bus_protocol_checker.sv - directed self-checking bench for bus_protocol_checker
module tb_bus_protocol_checker;

  localparam int NUM_CH  = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic                       CLK;
  logic                       nRST;
  logic                       clear;
  logic [NUM_CH-1:0]          ren;
  logic [NUM_CH-1:0]          wen;
  logic [NUM_CH-1:0]          busy;
  logic [NUM_CH*ADDR_W-1:0]   addr;
  logic [NUM_CH*DATA_W-1:0]   wdata;
  logic [NUM_CH*DATA_W/8-1:0] byte_en;
  logic [NUM_CH-1:0]          pending;
  logic [NUM_CH-1:0]          err_pulse;
  logic [NUM_CH*4-1:0]        err_flags;
  logic [NUM_CH*CNT_W-1:0]    txn_count;
  logic                       any_err;

  int checks;
  int failures;

  bus_protocol_checker #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear     (clear),
    .ren       (ren),
    .wen       (wen),
    .busy      (busy),
    .addr      (addr),
    .wdata     (wdata),
    .byte_en   (byte_en),
    .pending   (pending),
    .err_pulse (err_pulse),
    .err_flags (err_flags),
    .txn_count (txn_count),
    .any_err   (any_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRST     = 1'b1;
    clear    = 1'b0;
    ren      = '0;
    wen      = '0;
    busy     = '0;
    addr     = '0;
    wdata    = '0;
    byte_en  = '0;
    #2 nRST  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_pending",   64'(pending),   64'h0);
    check("rst_err_pulse", 64'(err_pulse), 64'h0);
    check("rst_err_flags", 64'(err_flags), 64'h0);
    check("rst_txn_count", 64'(txn_count), 64'h0);
    check("rst_any_err",   64'(any_err),   64'h0);
    nRST = 1'b1;
    tick();

    // Zero-wait reads, back to back: five completions on ch0
    ren[0]       = 1'b1;
    addr[31:0]   = 32'h10;
    byte_en[3:0] = 4'hF;
    repeat (5) tick();
    check("zw_txn_count", 64'(txn_count), 64'd5);
    check("zw_pending",   64'(pending),   64'h0);
    check("zw_err_flags", 64'(err_flags), 64'h0);
    ren[0] = 1'b0;
    tick();

    // Write stalled three cycles then completes
    wen[0]      = 1'b1;
    addr[31:0]  = 32'h100;
    wdata[31:0] = 32'hDEAD_BEEF;
    busy[0]     = 1'b1;
    tick();
    check("stall_pending_1", 64'(pending), 64'h1);
    tick();
    check("stall_pending_2", 64'(pending), 64'h1);
    tick();
    check("stall_pending_3", 64'(pending), 64'h1);
    busy[0] = 1'b0;
    tick();
    check("stall_done_pending", 64'(pending),   64'h0);
    check("stall_txn_count",    64'(txn_count), 64'd6);
    check("stall_err_flags",    64'(err_flags), 64'h0);
    wen[0] = 1'b0;
    tick();

    // Drop: read stalled two cycles then withdrawn
    ren[0]     = 1'b1;
    addr[31:0] = 32'h20;
    busy[0]    = 1'b1;
    tick();
    tick();
    ren[0]  = 1'b0;
    busy[0] = 1'b0;
    tick();
    check("drop_err_flags", 64'(err_flags), 64'h02);
    check("drop_err_pulse", 64'(err_pulse), 64'h1);
    check("drop_pending",   64'(pending),   64'h0);
    check("drop_any_err",   64'(any_err),   64'h1);
    tick();
    check("drop_pulse_gone", 64'(err_pulse), 64'h0);
    check("drop_sticky",     64'(err_flags), 64'h02);
    check("drop_txn_count",  64'(txn_count), 64'd6);

    // Clear zeroes flags and counters
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_err_flags", 64'(err_flags), 64'h0);
    check("clr_txn_count", 64'(txn_count), 64'h0);
    check("clr_any_err",   64'(any_err),   64'h0);

    // Mutate then timeout on a stalled read (TIMEOUT=4)
    ren[0]     = 1'b1;
    addr[31:0] = 32'h40;
    busy[0]    = 1'b1;
    tick();
    check("mut_pending", 64'(pending), 64'h1);
    addr[31:0] = 32'h44;
    tick();
    check("mut_err_pulse", 64'(err_pulse), 64'h1);
    check("mut_err_flags", 64'(err_flags), 64'h04);
    wdata[31:0] = 32'h1234_5678;  // ignored for a read
    tick();
    check("mut_rd_wdata_ignored", 64'(err_pulse), 64'h0);
    tick();
    check("tmo_err_pulse", 64'(err_pulse), 64'h1);
    check("tmo_err_flags", 64'(err_flags), 64'h0C);
    check("tmo_pending",   64'(pending),   64'h1);
    tick();
    check("tmo_no_repeat",     64'(err_pulse), 64'h0);
    check("tmo_pending_still", 64'(pending),   64'h1);
    busy[0] = 1'b0;
    tick();
    check("tmo_done_pending", 64'(pending),   64'h0);
    check("tmo_txn_count",    64'(txn_count), 64'd1);
    check("tmo_done_pulse",   64'(err_pulse), 64'h0);
    ren[0] = 1'b0;
    tick();

    // BOTH on ch1 while ch0 completes normally
    clear = 1'b1;
    tick();
    clear  = 1'b0;
    ren    = 2'b11;
    wen[1] = 1'b1;
    tick();
    check("both_err_flags", 64'(err_flags), 64'h10);
    check("both_err_pulse", 64'(err_pulse), 64'h2);
    check("both_any_err",   64'(any_err),   64'h1);
    check("both_txn_count", 64'(txn_count), 64'h09);
    ren[0] = 1'b0;

    // Violation in the clear cycle wins over the clear
    clear = 1'b1;
    tick();
    check("clr_win_err_flags", 64'(err_flags), 64'h10);
    check("clr_win_txn_count", 64'(txn_count), 64'h0);
    ren = '0;
    wen = '0;
    tick();
    clear = 1'b0;
    check("clr_after_err_flags", 64'(err_flags), 64'h0);

    // Saturation: nine completions on a 3-bit counter
    ren[0] = 1'b1;
    repeat (9) tick();
    check("sat_txn_count", 64'(txn_count), 64'd7);

    // Reset mid-stall discards everything
    busy[0] = 1'b1;
    ren[1]  = 1'b1;
    wen[1]  = 1'b1;
    tick();
    check("prerst_pending",   64'(pending),   64'h1);
    check("prerst_err_flags", 64'(err_flags), 64'h10);
    nRST = 1'b0;
    #1;
    check("midrst_pending",   64'(pending),   64'h0);
    check("midrst_err_flags", 64'(err_flags), 64'h0);
    check("midrst_txn_count", 64'(txn_count), 64'h0);
    check("midrst_err_pulse", 64'(err_pulse), 64'h0);
    check("midrst_any_err",   64'(any_err),   64'h0);
    ren  = '0;
    wen  = '0;
    busy = '0;
    tick();
    nRST = 1'b1;
    tick();
    check("postrst_pending",   64'(pending),   64'h0);
    check("postrst_err_flags", 64'(err_flags), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
